// File: rtl/add_seq_arb_pkg.sv
// Shared types and constants for the nibble-serial arbitrated adder.
package add_seq_arb_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module add_cla4
  import add_seq_arb_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  // Propagate/generate terms and fully expanded lookahead carries.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[NIB_W-1:0];
    cout = c[NIB_W];
  end

endmodule

// File: rtl/add_seq_arb.sv
// Two-requester round-robin front end sharing one 4-bit CLA slice for
// WIDTH-bit additions, one nibble per cycle, LSB first.
// Optional feature: define ADD_SUB_EN to add req_sub[1:0] (A-B via inverted B, carry-in 1).
module add_seq_arb
  import add_seq_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               r,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
`ifdef ADD_SUB_EN
  input  logic [1:0]         req_sub,
`endif
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_cout,
  output logic               res_id,
  output logic               busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               prio;
  logic               id_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;

  logic               grant_c;
  logic               accept_c;
  logic               last_c;
  logic               hs_c;
  logic               sub_sel_c;
  logic [WIDTH-1:0]   a_sel_c;
  logic [WIDTH-1:0]   b_sel_c;
  logic [NIB_W-1:0]   nib_s;
  logic               nib_cout;
  logic [WIDTH+NIB_W-1:0] sum_cat_c;
  logic [WIDTH-1:0]   sum_nxt_c;

  add_cla4 u_cla (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Winner's operands; subtraction folds into B inversion at capture time.
  always_comb begin
    grant_c = (req_valid == 2'b11) ? prio : req_valid[1];
    a_sel_c = grant_c ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
    b_sel_c = grant_c ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
`ifdef ADD_SUB_EN
    sub_sel_c = req_sub[grant_c];
`else
    sub_sel_c = 1'b0;
`endif
    sum_cat_c = {nib_s, sum_sh};
    sum_nxt_c = sum_cat_c[WIDTH+NIB_W-1:NIB_W];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (r) state <= ST_IDLE;
    else   state <= state_nxt;
  end

  // Next state, arbiter grant and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    hs_c      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          accept_c  = 1'b1;
          req_ready = grant_c ? 2'b10 : 2'b01;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx == IDX_W'(NIB - 1)) begin
          last_c    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_valid && res_ready) begin
          hs_c      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (r) begin
      state_nxt = ST_IDLE;
      req_ready = 2'b00;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      hs_c      = 1'b0;
    end
  end

  // Datapath: capture, nibble-serial add, and result publication.
  // The partial sum builds in sum_sh so res_sum keeps the previous result until completion.
  always_ff @(posedge clk) begin
    if (r) begin
      prio      <= 1'b0;
      id_q      <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      if (accept_c) begin
        a_sh  <= a_sel_c;
        b_sh  <= sub_sel_c ? ~b_sel_c : b_sel_c;
        carry <= sub_sel_c;
        idx   <= '0;
        id_q  <= grant_c;
        prio  <= ~grant_c;
      end
      if (state == ST_RUN) begin
        a_sh   <= a_sh >> NIB_W;
        b_sh   <= b_sh >> NIB_W;
        carry  <= nib_cout;
        idx    <= idx + IDX_W'(1);
        sum_sh <= sum_nxt_c;
        if (last_c) begin
          res_sum   <= sum_nxt_c;
          res_cout  <= nib_cout;
          res_id    <= id_q;
          res_valid <= 1'b1;
        end
      end
      if (hs_c) res_valid <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
